// File: rtl/id_exe_reg_if.sv
// id_exe_reg_if -- ID/EXE pipeline boundary bundle.
//   ID_*             : decoded instruction entering the EXE stage
//   EXE_branch_taken : redirect from the EXE stage
//   mem_stall        : global freeze from the memory side
//   EXE_*            : registered instruction now in the EXE stage
//   load_use_stall   : freeze PC and IF/ID for one cycle
//   IF_ID_flush      : kill the IF/ID slot
//   stall_cnt        : saturating count of load-use bubbles
//   flush_cnt        : saturating count of branch bubbles
// master = pipeline control side, slave = id_exe_reg.
interface id_exe_reg_if;
    logic        ID_valid;
    logic [12:0] ID_ctrl;
    logic [31:0] ID_pc;
    logic [31:0] ID_imm;
    logic [31:0] ID_rs1_data;
    logic [31:0] ID_rs2_data;
    logic [4:0]  ID_rs1_addr;
    logic [4:0]  ID_rs2_addr;
    logic [4:0]  ID_rd_addr;
    logic [2:0]  ID_funct3;
    logic [6:0]  ID_funct7;
    logic        EXE_branch_taken;
    logic        mem_stall;

    logic        EXE_valid;
    logic [12:0] EXE_ctrl;
    logic [31:0] EXE_pc;
    logic [31:0] EXE_imm;
    logic [31:0] EXE_rs1_data;
    logic [31:0] EXE_rs2_data;
    logic [4:0]  EXE_rs1_addr;
    logic [4:0]  EXE_rs2_addr;
    logic [4:0]  EXE_rd_addr;
    logic [2:0]  EXE_funct3;
    logic [6:0]  EXE_funct7;
    logic        load_use_stall;
    logic        IF_ID_flush;
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;

    modport master (
        output ID_valid, ID_ctrl, ID_pc, ID_imm, ID_rs1_data, ID_rs2_data,
               ID_rs1_addr, ID_rs2_addr, ID_rd_addr, ID_funct3, ID_funct7,
               EXE_branch_taken, mem_stall,
        input  EXE_valid, EXE_ctrl, EXE_pc, EXE_imm, EXE_rs1_data, EXE_rs2_data,
               EXE_rs1_addr, EXE_rs2_addr, EXE_rd_addr, EXE_funct3, EXE_funct7,
               load_use_stall, IF_ID_flush, stall_cnt, flush_cnt
    );

    modport slave (
        input  ID_valid, ID_ctrl, ID_pc, ID_imm, ID_rs1_data, ID_rs2_data,
               ID_rs1_addr, ID_rs2_addr, ID_rd_addr, ID_funct3, ID_funct7,
               EXE_branch_taken, mem_stall,
        output EXE_valid, EXE_ctrl, EXE_pc, EXE_imm, EXE_rs1_data, EXE_rs2_data,
               EXE_rs1_addr, EXE_rs2_addr, EXE_rd_addr, EXE_funct3, EXE_funct7,
               load_use_stall, IF_ID_flush, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/id_exe_reg.sv
// id_exe_reg -- ID/EXE pipeline register with load-use hazard detection,
// branch flush and saturating stall/flush event counters.
//   clk : system clock, all state on the rising edge
//   rst : asynchronous active-low reset
//   bus : id_exe_reg_if.slave (ID inputs, EXE outputs, hazard/flush, counters)
// ctrl bit map: [12:10] ALU_Ctrl_op, [9] EXE_pc_sel, [8] ALU_rs2_sel,
// [7:6] branch_signal, [5] MEM_rd_sel, [4] DM_read, [3] DM_write,
// [2] reg_file_write, [1] reg_file_FP_write, [0] WB_data_sel.
module id_exe_reg (
    input logic         clk,
    input logic         rst,
    id_exe_reg_if.slave bus
);
    typedef enum logic [1:0] {
        ACT_LOAD,
        ACT_STALL,
        ACT_FLUSH,
        ACT_HOLD
    } act_e;

    act_e        act;

    logic        exe_valid;
    logic [12:0] exe_ctrl;
    logic [31:0] exe_pc;
    logic [31:0] exe_imm;
    logic [31:0] exe_rs1_data;
    logic [31:0] exe_rs2_data;
    logic [4:0]  exe_rs1_addr;
    logic [4:0]  exe_rs2_addr;
    logic [4:0]  exe_rd_addr;
    logic [2:0]  exe_funct3;
    logic [6:0]  exe_funct7;
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;

    logic        dest_written;
    logic        rd_matches;
    logic        hazard;

    // FP loads always write (f0 is a real register); integer loads to x0 do not.
    assign dest_written = exe_ctrl[1] | (exe_ctrl[2] & (exe_rd_addr != 5'd0));
    assign rd_matches   = (exe_rd_addr == bus.ID_rs1_addr) | (exe_rd_addr == bus.ID_rs2_addr);
    assign hazard       = bus.ID_valid & exe_valid & exe_ctrl[4] & dest_written & rd_matches;

    always_comb begin
        act = ACT_LOAD;
        if (bus.mem_stall)
            act = ACT_HOLD;
        else if (bus.EXE_branch_taken)
            act = ACT_FLUSH;
        else if (hazard)
            act = ACT_STALL;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            exe_valid    <= 1'b0;
            exe_ctrl     <= '0;
            exe_pc       <= '0;
            exe_imm      <= '0;
            exe_rs1_data <= '0;
            exe_rs2_data <= '0;
            exe_rs1_addr <= '0;
            exe_rs2_addr <= '0;
            exe_rd_addr  <= '0;
            exe_funct3   <= '0;
            exe_funct7   <= '0;
            stall_cnt    <= '0;
            flush_cnt    <= '0;
        end else begin
            case (act)
                ACT_LOAD: begin
                    exe_valid    <= bus.ID_valid;
                    exe_ctrl     <= bus.ID_valid ? bus.ID_ctrl : '0;
                    exe_pc       <= bus.ID_pc;
                    exe_imm      <= bus.ID_imm;
                    exe_rs1_data <= bus.ID_rs1_data;
                    exe_rs2_data <= bus.ID_rs2_data;
                    exe_rs1_addr <= bus.ID_rs1_addr;
                    exe_rs2_addr <= bus.ID_rs2_addr;
                    exe_rd_addr  <= bus.ID_rd_addr;
                    exe_funct3   <= bus.ID_funct3;
                    exe_funct7   <= bus.ID_funct7;
                end
                ACT_STALL: begin
                    exe_valid <= 1'b0;
                    exe_ctrl  <= '0;
                    if (stall_cnt != '1)
                        stall_cnt <= stall_cnt + 16'd1;
                end
                ACT_FLUSH: begin
                    exe_valid <= 1'b0;
                    exe_ctrl  <= '0;
                    if (flush_cnt != '1)
                        flush_cnt <= flush_cnt + 16'd1;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.EXE_valid      = exe_valid;
    assign bus.EXE_ctrl       = exe_ctrl;
    assign bus.EXE_pc         = exe_pc;
    assign bus.EXE_imm        = exe_imm;
    assign bus.EXE_rs1_data   = exe_rs1_data;
    assign bus.EXE_rs2_data   = exe_rs2_data;
    assign bus.EXE_rs1_addr   = exe_rs1_addr;
    assign bus.EXE_rs2_addr   = exe_rs2_addr;
    assign bus.EXE_rd_addr    = exe_rd_addr;
    assign bus.EXE_funct3     = exe_funct3;
    assign bus.EXE_funct7     = exe_funct7;
    assign bus.stall_cnt      = stall_cnt;
    assign bus.flush_cnt      = flush_cnt;
    assign bus.load_use_stall = hazard;
    assign bus.IF_ID_flush    = bus.EXE_branch_taken & ~bus.mem_stall;
endmodule

// File: tb/tb_id_exe_reg.sv
// tb_id_exe_reg -- self-checking bench for id_exe_reg.
// Expected EXE state is computed from the driven inputs before each edge,
// queued, and popped for comparison after the edge.
module tb_id_exe_reg;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    id_exe_reg_if bus ();

    id_exe_reg dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic        valid;
        logic [12:0] ctrl;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [31:0] rs1d;
        logic [31:0] rs2d;
        logic [4:0]  rs1a;
        logic [4:0]  rs2a;
        logic [4:0]  rda;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [15:0] scnt;
        logic [15:0] fcnt;
    } model_t;

    model_t m;
    model_t sb[$];
    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp)
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        else
            n_pass++;
    endtask

    // Hazard rule written out from the ctrl bit map: DM_read with a real destination.
    function automatic logic model_hazard(input model_t s);
        logic is_load, writes, hit;
        is_load = s.valid && s.ctrl[4];
        writes  = s.ctrl[1] || (s.ctrl[2] && s.rda != 5'd0);
        hit     = (s.rda == bus.ID_rs1_addr) || (s.rda == bus.ID_rs2_addr);
        return bus.ID_valid && is_load && writes && hit;
    endfunction

    function automatic model_t model_next(input model_t s);
        model_t n;
        n = s;
        if (bus.mem_stall) begin
            n = s;
        end else if (bus.EXE_branch_taken) begin
            n.valid = 1'b0;
            n.ctrl  = 13'h0;
            n.fcnt  = (s.fcnt == 16'hFFFF) ? 16'hFFFF : s.fcnt + 16'd1;
        end else if (model_hazard(s)) begin
            n.valid = 1'b0;
            n.ctrl  = 13'h0;
            n.scnt  = (s.scnt == 16'hFFFF) ? 16'hFFFF : s.scnt + 16'd1;
        end else begin
            n.valid = bus.ID_valid;
            n.ctrl  = bus.ID_valid ? bus.ID_ctrl : 13'h0;
            n.pc    = bus.ID_pc;
            n.imm   = bus.ID_imm;
            n.rs1d  = bus.ID_rs1_data;
            n.rs2d  = bus.ID_rs2_data;
            n.rs1a  = bus.ID_rs1_addr;
            n.rs2a  = bus.ID_rs2_addr;
            n.rda   = bus.ID_rd_addr;
            n.f3    = bus.ID_funct3;
            n.f7    = bus.ID_funct7;
        end
        return n;
    endfunction

    task automatic compare_state(input string tag, input model_t e);
        check({tag, ".valid"}, 32'(bus.EXE_valid),    32'(e.valid));
        check({tag, ".ctrl"},  32'(bus.EXE_ctrl),     32'(e.ctrl));
        check({tag, ".pc"},    bus.EXE_pc,            e.pc);
        check({tag, ".imm"},   bus.EXE_imm,           e.imm);
        check({tag, ".rs1d"},  bus.EXE_rs1_data,      e.rs1d);
        check({tag, ".rs2d"},  bus.EXE_rs2_data,      e.rs2d);
        check({tag, ".rs1a"},  32'(bus.EXE_rs1_addr), 32'(e.rs1a));
        check({tag, ".rs2a"},  32'(bus.EXE_rs2_addr), 32'(e.rs2a));
        check({tag, ".rda"},   32'(bus.EXE_rd_addr),  32'(e.rda));
        check({tag, ".f3"},    32'(bus.EXE_funct3),   32'(e.f3));
        check({tag, ".f7"},    32'(bus.EXE_funct7),   32'(e.f7));
        check({tag, ".scnt"},  32'(bus.stall_cnt),    32'(e.scnt));
        check({tag, ".fcnt"},  32'(bus.flush_cnt),    32'(e.fcnt));
    endtask

    task automatic drive_id(input logic v, input logic [12:0] ctrl, input logic [31:0] pc,
                            input logic [4:0] rs1a, input logic [4:0] rs2a, input logic [4:0] rda);
        bus.ID_valid    = v;
        bus.ID_ctrl     = ctrl;
        bus.ID_pc       = pc;
        bus.ID_imm      = $urandom;
        bus.ID_rs1_data = $urandom;
        bus.ID_rs2_data = $urandom;
        bus.ID_rs1_addr = rs1a;
        bus.ID_rs2_addr = rs2a;
        bus.ID_rd_addr  = rda;
        bus.ID_funct3   = 3'($urandom);
        bus.ID_funct7   = 7'($urandom);
    endtask

    // Called at posedge+1 with inputs already driven; returns at the next posedge+1.
    task automatic step(input string tag);
        model_t e;
        #2;
        check({tag, ".lus"},   32'(bus.load_use_stall), 32'(model_hazard(m)));
        check({tag, ".flush"}, 32'(bus.IF_ID_flush),    32'(bus.EXE_branch_taken && !bus.mem_stall));
        sb.push_back(model_next(m));
        @(posedge clk);
        #1;
        e = sb.pop_front();
        compare_state(tag, e);
        m = e;
    endtask

    // Unchecked run of branch bubbles; the model is advanced in one go afterwards.
    task automatic burst_flush(input int unsigned n);
        int unsigned total;
        bus.EXE_branch_taken = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        total   = int'(m.fcnt) + n;
        m.valid = 1'b0;
        m.ctrl  = 13'h0;
        m.fcnt  = (total > 32'd65535) ? 16'hFFFF : 16'(total);
    endtask

    initial begin
        rst = 1'b0;
        bus.EXE_branch_taken = 1'b0;
        bus.mem_stall        = 1'b0;
        drive_id(1'b0, 13'h0, 32'h0, 5'd0, 5'd0, 5'd0);
        m = '0;
        #3;
        compare_state("reset", m);
        check("reset.lus", 32'(bus.load_use_stall), 32'h0);

        @(negedge clk);
        rst = 1'b1;

        // Plain ALU traffic, no DM_read so no hazard.
        for (int i = 0; i < 4; i++) begin
            drive_id(1'b1, 13'($urandom) & ~13'h0010, 32'($urandom), 5'($urandom), 5'($urandom), 5'($urandom));
            if (i == 0) begin
                #2;
                step("load0");
            end else begin
                step("alu");
            end
        end
        check("load.valid", 32'(bus.EXE_valid), 32'h1);

        // Invalid slot: ctrl forced to zero.
        drive_id(1'b0, 13'h1FFF, 32'h44, 5'd1, 5'd2, 5'd3);
        step("inval");
        check("inval.ctrl", 32'(bus.EXE_ctrl), 32'h0);

        // LW x5 then dependent op.
        drive_id(1'b1, 13'h0014, 32'h100, 5'd1, 5'd2, 5'd5);
        step("lw5");
        drive_id(1'b1, 13'h0004, 32'h104, 5'd5, 5'd6, 5'd7);
        #1;
        check("lw5.lus_on", 32'(bus.load_use_stall), 32'h1);
        step("lw5.bubble");
        check("lw5.bub_valid", 32'(bus.EXE_valid), 32'h0);
        check("lw5.scnt", 32'(bus.stall_cnt), 32'h1);
        #1;
        check("lw5.lus_off", 32'(bus.load_use_stall), 32'h0);
        step("lw5.dep");
        check("lw5.dep_valid", 32'(bus.EXE_valid), 32'h1);
        check("lw5.dep_pc", bus.EXE_pc, 32'h104);

        // LW x0: no hazard.
        drive_id(1'b1, 13'h0014, 32'h200, 5'd1, 5'd2, 5'd0);
        step("lwx0");
        drive_id(1'b1, 13'h0004, 32'h204, 5'd3, 5'd0, 5'd9);
        #1;
        check("lwx0.lus", 32'(bus.load_use_stall), 32'h0);
        step("lwx0.dep");
        check("lwx0.scnt", 32'(bus.stall_cnt), 32'h1);

        // FLW f0: hazard even on index 0.
        drive_id(1'b1, 13'h0012, 32'h300, 5'd1, 5'd2, 5'd0);
        step("flw");
        drive_id(1'b1, 13'h0004, 32'h304, 5'd0, 5'd9, 5'd10);
        #1;
        check("flw.lus", 32'(bus.load_use_stall), 32'h1);
        step("flw.bubble");
        check("flw.scnt", 32'(bus.stall_cnt), 32'h2);
        step("flw.dep");

        // Branch together with load-use: one bubble counted as a flush.
        drive_id(1'b1, 13'h0014, 32'h400, 5'd1, 5'd2, 5'd7);
        step("br_lu.lw");
        drive_id(1'b1, 13'h0004, 32'h404, 5'd7, 5'd3, 5'd11);
        bus.EXE_branch_taken = 1'b1;
        #1;
        check("br_lu.lus", 32'(bus.load_use_stall), 32'h1);
        check("br_lu.flush", 32'(bus.IF_ID_flush), 32'h1);
        step("br_lu");
        check("br_lu.fcnt", 32'(bus.flush_cnt), 32'h1);
        check("br_lu.scnt", 32'(bus.stall_cnt), 32'h2);
        bus.EXE_branch_taken = 1'b0;
        step("br_lu.next");

        // mem_stall freeze with branch pending.
        drive_id(1'b1, 13'h0014, 32'h500, 5'd1, 5'd2, 5'd8);
        step("ms.lw");
        drive_id(1'b1, 13'h0004, 32'h504, 5'd4, 5'd8, 5'd12);
        bus.EXE_branch_taken = 1'b1;
        bus.mem_stall        = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("ms.lus", 32'(bus.load_use_stall), 32'h1);
            check("ms.flush", 32'(bus.IF_ID_flush), 32'h0);
            step("ms.hold");
            check("ms.pc", bus.EXE_pc, 32'h500);
            check("ms.fcnt", 32'(bus.flush_cnt), 32'h1);
        end
        bus.mem_stall = 1'b0;
        step("ms.release");
        check("ms.rel_valid", 32'(bus.EXE_valid), 32'h0);
        check("ms.rel_fcnt", 32'(bus.flush_cnt), 32'h2);
        bus.EXE_branch_taken = 1'b0;
        step("ms.after");

        // Flush counter saturation.
        burst_flush(65535);
        check("sat.fcnt", 32'(bus.flush_cnt), 32'hFFFF);
        step("sat.more");
        check("sat.hold", 32'(bus.flush_cnt), 32'hFFFF);
        bus.EXE_branch_taken = 1'b0;
        step("sat.load");

        // Asynchronous reset in the middle of a load-use stall.
        drive_id(1'b1, 13'h0014, 32'h600, 5'd1, 5'd2, 5'd4);
        step("rst.lw");
        drive_id(1'b1, 13'h0004, 32'h604, 5'd4, 5'd5, 5'd6);
        #1;
        check("rst.lus_pre", 32'(bus.load_use_stall), 32'h1);
        #1;
        rst = 1'b0;
        #1;
        m = '0;
        sb.delete();
        compare_state("rst.mid", m);
        check("rst.lus", 32'(bus.load_use_stall), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        drive_id(1'b1, 13'h0004, 32'h700, 5'd1, 5'd2, 5'd3);
        step("rst.first");
        check("rst.first_valid", 32'(bus.EXE_valid), 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
